// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/add_sub_n.sv
// Combinational N-bit two's-complement adder/subtractor with an N+1-bit
// sign-extended result, so the sum of two N-bit signed values never overflows.
module add_sub_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         fn,
  output logic [N:0]   Y
);

  logic [N:0] a_ext;
  logic [N:0] b_ext;

  assign a_ext = {A[N-1], A};
  assign b_ext = {B[N-1], B};

  // Any carry out of bit N is dropped by the N+1-bit result width.
  assign Y = fn ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/signed_mult_seq.sv
// Sequential shift-and-add two's-complement multiplier: one ADD and one SHIFT
// cycle per multiplier bit, with a subtract on the final (sign-bit) iteration.
module signed_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A_in,
  input  logic [WIDTH-1:0]     B_in,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Prod,
  output logic                 X
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic             last_iter;

  assign last_iter = (cnt_q == LAST_CNT);

  // The multiplier's sign bit carries negative weight, hence subtract on it.
  add_sub_n #(.N(WIDTH)) u_add_sub (
    .A  (areg_q),
    .B  (mcand_q),
    .fn (last_iter),
    .Y  (sum)
  );

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          breg_d  = B_in;
          mcand_d = A_in;
          areg_d  = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        if (breg_q[0]) begin
          {x_d, areg_d} = sum;
        end
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // X is replicated into the vacated top bit and also keeps its value.
        areg_d = {x_q, areg_q[WIDTH-1:1]};
        breg_d = {areg_q[0], breg_q[WIDTH-1:1]};
        cnt_d  = cnt_q + WIDTH'(1);
        if (last_iter) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Prod = {areg_q, breg_q};
  assign X    = x_q;

endmodule
